// File: rtl/demux2_pair_collector.sv
// Purpose: route tagged serial samples to ch0/ch1 registers and present completed {ch0, ch1} pairs.
// Latency: out_valid rises 1 cycle after the input transfer that completes a pair.
// Backpressure: a held pair stalls input (in_ready=0) until out_ready; release and reload share one edge.
module demux2_pair_collector #(
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out0,
  output logic [W-1:0]  out1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_dup,
  output logic [CW-1:0] pair_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    GOT0  = 2'd1,
    GOT1  = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   in_xfer;
  logic   out_xfer;
  logic   dup_nxt;

  // in_ready depends only on state and out_ready, never on in_valid
  assign in_ready  = (state != FULL) || out_ready;
  assign out_valid = (state == FULL);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and duplicate-tag detection
  always_comb begin
    state_nxt = state;
    dup_nxt   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = in_sel ? GOT1 : GOT0;
        end
      end
      GOT0: begin
        if (in_xfer) begin
          if (in_sel) begin
            state_nxt = FULL;
          end else begin
            dup_nxt = 1'b1;
          end
        end
      end
      GOT1: begin
        if (in_xfer) begin
          if (!in_sel) begin
            state_nxt = FULL;
          end else begin
            dup_nxt = 1'b1;
          end
        end
      end
      FULL: begin
        // in_xfer can only happen here together with out_xfer
        if (out_xfer) begin
          if (in_xfer) begin
            state_nxt = in_sel ? GOT1 : GOT0;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Channel registers load only on an accepted sample with the matching tag; never cleared on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0 <= '0;
      out1 <= '0;
    end else if (in_xfer) begin
      if (in_sel) begin
        out1 <= in_data;
      end else begin
        out0 <= in_data;
      end
    end
  end

  // Registered one-cycle duplicate-tag pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup <= 1'b0;
    end else begin
      err_dup <= dup_nxt;
    end
  end

  // Consumed-pair counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
    end else if (out_xfer) begin
      pair_count <= pair_count + CW'(1);
    end
  end

endmodule

// File: doc/demux2_pair_collector.md
# demux2_pair_collector

Two-channel stream demultiplexer and pair collector: the receive-side counterpart of the team's 2:1 data-flow multiplexer. It accepts a serial stream of samples, each tagged with a select bit naming its source channel. It routes each sample to channel 0 or channel 1 storage and presents a complete {ch0, ch1} pair downstream under a valid/ready handshake. It sits after a time-multiplexed link, where two per-channel values share one wire, and restores them as parallel words.

## Interface
- W, 1, data width per channel sample
- CW, 8, width of the completed-pair counter
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_data  input  W  sample value
- in_sel  input  1  channel tag: 0 routes to out0, 1 routes to out1
- in_valid  input  1  sample present
- in_ready  output  1  block can accept a sample this cycle
- out0  output  W  channel-0 value of the current pair
- out1  output  W  channel-1 value of the current pair
- out_valid  output  1  complete pair presented
- out_ready  input  1  downstream consumes pair
- err_dup  output  1  one-cycle pulse: repeated channel tag overwrote a pending sample
- pair_count  output  CW  number of pairs consumed, wraps modulo 2^CW

## Operation
- Transfer rules:
  - Input transfer = in_valid && in_ready at a rising clk edge.
  - Output transfer = out_valid && out_ready at a rising clk edge.
- FSM states and outputs:
  - EMPTY: nothing held.
  - GOT0: only ch0 held.
  - GOT1: only ch1 held.
  - FULL: pair held; out_valid=1 only here.
- in_ready = (state != FULL) || out_ready. It is combinational from state and out_ready, with no path from in_valid.
- Transitions on input transfer:
  - EMPTY: sel=0 goes to GOT0; sel=1 goes to GOT1.
  - GOT0: sel=1 goes to FULL. sel=0 overwrites out0, pulses err_dup, and stays in GOT0.
  - GOT1: symmetric to GOT0.
  - FULL with simultaneous output transfer: the pair is released, pair_count increments, and the new sample loads its channel. Next state is GOT0 or GOT1 per sel.
- FULL, output transfer, no input: go to EMPTY and increment pair_count.
- FULL, no output transfer: hold all state. in_ready=0, so no input is taken.
- Data registers:
  - out0 and out1 load only on an input transfer with the matching sel.
  - Otherwise they hold their value; they are not cleared on release.
  - When out_valid=0, their values are don't-care to consumers.
- pair_count increments by 1 per output transfer. It wraps from 2^CW-1 to 0 without flagging.
- err_dup is registered. It is high for exactly the cycle after the offending transfer, and low otherwise.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=EMPTY; out0=0, out1=0, out_valid=0, err_dup=0, pair_count=0.
  - in_ready=1 as soon as reset releases.
- Latency: out_valid rises in the cycle after the edge that accepts the completing sample, i.e. 1 cycle from the second input transfer.
- Throughput: one sample per cycle sustained when out_ready=1. With alternating sel, that is one pair every 2 cycles, with no bubble in FULL.
- Backpressure:
  - While out_valid=1 and out_ready=0, out0, out1 and out_valid are stable.
  - in_ready=0 and no input is lost.
- Reset mid-operation: any held sample or pending pair is discarded. pair_count returns to 0 and does not count the discarded pair.
- rst_n deassertion is synchronized externally. The block assumes it is released clear of the clk edge.

## Test plan
- Reset check:
  - Stimulus: assert rst_n=0 mid-cycle while in GOT0 with out0=1.
  - Required: out0=0, out_valid=0 and pair_count=0 immediately. in_ready=1 after release.
- Basic pair (W=1, out_ready=1):
  - Stimulus: send {sel=0,data=1} then {sel=1,data=0} on consecutive cycles.
  - Required: next cycle out_valid=1, out0=1, out1=0. Following cycle pair_count=1 and out_valid=0.
- Reverse order plus full sweep:
  - Stimulus: sel=1 first, then sel=0, for all four data combinations 00, 01, 10, 11.
  - Required: each pair appears correctly on out0/out1 and pair_count ends at 4.
- Backpressure:
  - Stimulus: complete a pair with out_ready=0 held 3 cycles while in_valid=1.
  - Required: in_ready=0, outputs stable, no sample accepted. Then raise out_ready with {sel=0,data=1} presented: pair released and state=GOT0, out0=1, in the same edge.
- Duplicate tag:
  - Stimulus: {sel=0,data=0} then {sel=0,data=1}.
  - Required: err_dup=1 for exactly one cycle, out0=1, still no out_valid. A following {sel=1} completes the pair with out0=1.
- Counter wrap (CW=2):
  - Stimulus: complete 5 pairs.
  - Required: pair_count sequence 1, 2, 3, 0, 1; no error asserted.
